// File: rtl/threshold_cv_mul_arbiter.sv
// Round-robin arbiter that lets NUM_REQ requesters share one pipelined 16x16 multiplier.
// Products return on a single tagged result port; the multiplier clock-enable carries backpressure.

module threshold_cv_mul_mul_16ns_16ns_32_4_1 #(
   parameter int LATENCY = 3
) (
   input  logic        clk,
   input  logic        ce,
   input  logic [15:0] din0,
   input  logic [15:0] din1,
   output logic [31:0] dout
);

   logic [31:0] prod_q [LATENCY];
   logic [31:0] prod_d [LATENCY];

   always_comb begin
      prod_d[0] = {16'd0, din0} * {16'd0, din1};
      for (int i = 1; i < LATENCY; i++) begin
         prod_d[i] = prod_q[i-1];
      end
   end

   // Datapath only: no reset, frozen whenever ce is low.
   always_ff @(posedge clk) begin
      if (ce) begin
         prod_q <= prod_d;
      end
   end

   assign dout = prod_q[LATENCY-1];

endmodule

module threshold_cv_mul_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int ID_W        = 2,
   parameter int MUL_LATENCY = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_REQ-1:0]    req_valid,
   output logic [NUM_REQ-1:0]    req_ready,
   input  logic [NUM_REQ*16-1:0] req_a,
   input  logic [NUM_REQ*16-1:0] req_b,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [31:0]           res_data,
   output logic [ID_W-1:0]       res_id,
   output logic                  busy
);

   generate
      if (ID_W < $clog2(NUM_REQ) || ID_W < 1) begin : g_bad_id_w
         $error("threshold_cv_mul_arbiter: ID_W too small for NUM_REQ");
      end
      if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
         $error("threshold_cv_mul_arbiter: NUM_REQ must be 2..8");
      end
      if (MUL_LATENCY < 1) begin : g_bad_latency
         $error("threshold_cv_mul_arbiter: MUL_LATENCY must be at least 1");
      end
   endgenerate

   localparam logic [ID_W:0] NUM_REQ_X = (ID_W+1)'(NUM_REQ);

   logic                   stall;
   logic                   ce;
   logic                   issue;
   logic                   found;
   logic [2*NUM_REQ-1:0]   rot_vld;
   logic [ID_W-1:0]        off;
   logic [ID_W:0]          sel_sum;
   logic [ID_W:0]          nxt_sum;
   logic [ID_W-1:0]        sel;
   logic [15:0]            din0;
   logic [15:0]            din1;
   logic [31:0]            mul_dout;

   logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
   logic [MUL_LATENCY-1:0] tag_vld_q, tag_vld_d;
   logic [ID_W-1:0]        tag_id_q [MUL_LATENCY];
   logic [ID_W-1:0]        tag_id_d [MUL_LATENCY];

   assign stall = tag_vld_q[MUL_LATENCY-1] & ~res_ready;
   assign ce    = ~stall;

   // Rotate the valid vector so bit 0 is rr_ptr; the lowest set bit is the winner.
   always_comb begin
      rot_vld = {req_valid, req_valid} >> rr_ptr_q;
      found   = |rot_vld[NUM_REQ-1:0];
      off     = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (rot_vld[k]) begin
            off = k[ID_W-1:0];
         end
      end
      sel_sum = {1'b0, rr_ptr_q} + {1'b0, off};
      if (sel_sum >= NUM_REQ_X) begin
         sel_sum = sel_sum - NUM_REQ_X;
      end
      sel   = sel_sum[ID_W-1:0];
      issue = found & ce & ~reset;

      req_ready = '0;
      if (issue) begin
         req_ready[sel] = 1'b1;
      end
   end

   always_comb begin
      din0 = req_a[15:0];
      din1 = req_b[15:0];
      for (int i = 1; i < NUM_REQ; i++) begin
         if (sel == ID_W'(i)) begin
            din0 = req_a[16*i +: 16];
            din1 = req_b[16*i +: 16];
         end
      end
   end

   always_comb begin
      nxt_sum = sel_sum + 1'b1;
      if (nxt_sum >= NUM_REQ_X) begin
         nxt_sum = '0;
      end
      rr_ptr_d = rr_ptr_q;
      if (issue) begin
         rr_ptr_d = nxt_sum[ID_W-1:0];
      end

      tag_vld_d = tag_vld_q;
      tag_id_d  = tag_id_q;
      if (ce) begin
         tag_vld_d[0] = issue;
         tag_id_d[0]  = sel;
         for (int i = 1; i < MUL_LATENCY; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_id_d[i]  = tag_id_q[i-1];
         end
      end
   end

   // Control state: reset discards every in-flight tag.
   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr_q  <= '0;
         tag_vld_q <= '0;
      end else begin
         rr_ptr_q  <= rr_ptr_d;
         tag_vld_q <= tag_vld_d;
      end
   end

   always_ff @(posedge clk) begin
      tag_id_q <= tag_id_d;
   end

   threshold_cv_mul_mul_16ns_16ns_32_4_1 #(
      .LATENCY(MUL_LATENCY)
   ) u_mul (
      .clk (clk),
      .ce  (ce),
      .din0(din0),
      .din1(din1),
      .dout(mul_dout)
   );

   assign res_valid = tag_vld_q[MUL_LATENCY-1];
   assign res_id    = tag_id_q[MUL_LATENCY-1];
   assign res_data  = mul_dout;
   assign busy      = |tag_vld_q;

endmodule

// File: tb/tb_threshold_cv_mul_arbiter.sv
// Directed bench for threshold_cv_mul_arbiter (NUM_REQ=4, MUL_LATENCY=3).
// Steps: single op, max operands, fairness, backpressure, reset mid-flight.

module tb_threshold_cv_mul_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [63:0] req_a;
   logic [63:0] req_b;
   logic        res_valid;
   logic        res_ready;
   logic [31:0] res_data;
   logic [1:0]  res_id;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] exp3 [4];

   always #5 clk = ~clk;

   threshold_cv_mul_arbiter #(
      .NUM_REQ(4),
      .ID_W(2),
      .MUL_LATENCY(3)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_a    (req_a),
      .req_b    (req_b),
      .res_valid(res_valid),
      .res_ready(res_ready),
      .res_data (res_data),
      .res_id   (res_id),
      .busy     (busy)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
      req_a[16*i +: 16] = a;
      req_b[16*i +: 16] = b;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      reset     = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      res_ready = 1'b1;
      exp3[0] = 32'd2000;
      exp3[1] = 32'd3003;
      exp3[2] = 32'd4008;
      exp3[3] = 32'd5015;
      cyc();
      cyc();
      #1;
      chk("rst_res_valid", res_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", req_ready, 0);

      // Single op from requester 2
      reset = 1'b0;
      set_op(2, 16'd300, 16'd200);
      req_valid = 4'b0100;
      #1;
      chk("t1_ready", req_ready, 4'b0100);
      cyc();
      req_valid = '0;
      #1;
      chk("t1_lat1_valid", res_valid, 0);
      chk("t1_lat1_busy", busy, 1);
      cyc();
      #1;
      chk("t1_lat2_valid", res_valid, 0);
      cyc();
      #1;
      chk("t1_res_valid", res_valid, 1);
      chk("t1_res_data", res_data, 32'd60000);
      chk("t1_res_id", res_id, 2);
      chk("t1_busy", busy, 1);
      cyc();
      #1;
      chk("t1_done_valid", res_valid, 0);
      chk("t1_done_busy", busy, 0);

      // Max operands from requester 1; rr_ptr is 3 so search wraps 3,0,1
      set_op(1, 16'hFFFF, 16'hFFFF);
      req_valid = 4'b0010;
      #1;
      chk("t2_ready", req_ready, 4'b0010);
      cyc();
      req_valid = '0;
      cyc();
      cyc();
      #1;
      chk("t2_res_valid", res_valid, 1);
      chk("t2_res_data", res_data, 32'hFFFE0001);
      chk("t2_res_id", res_id, 1);
      cyc();

      // Fairness from reset: all four valid for 8 cycles
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      #1;
      chk("t3_busy_after_rst", busy, 0);
      for (int i = 0; i < 4; i++) set_op(i, 16'(i + 2), 16'(1000 + i));
      req_valid = 4'b1111;
      for (int k = 0; k < 11; k++) begin
         if (k == 8) req_valid = '0;
         #1;
         if (k < 8) chk("t3_grant", req_ready, 64'(1 << (k % 4)));
         else       chk("t3_no_grant", req_ready, 0);
         if (k >= 3) begin
            chk("t3_res_valid", res_valid, 1);
            chk("t3_res_id", res_id, 64'((k - 3) % 4));
            chk("t3_res_data", res_data, exp3[(k - 3) % 4]);
         end else begin
            chk("t3_res_idle", res_valid, 0);
         end
         cyc();
      end
      #1;
      chk("t3_drained", res_valid, 0);

      // Backpressure: three ops in flight, result port stalled 5 cycles
      set_op(0, 16'd7, 16'd9);
      set_op(1, 16'd11, 16'd13);
      set_op(2, 16'd100, 16'd1000);
      set_op(3, 16'd2, 16'd3);
      req_valid = 4'b0111;
      #1;
      chk("t4_grant0", req_ready, 4'b0001);
      cyc();
      req_valid = 4'b0110;
      #1;
      chk("t4_grant1", req_ready, 4'b0010);
      cyc();
      req_valid = 4'b0100;
      #1;
      chk("t4_grant2", req_ready, 4'b0100);
      cyc();
      req_valid = 4'b1000;
      res_ready = 1'b0;
      for (int s = 0; s < 5; s++) begin
         #1;
         chk("t4_stall_valid", res_valid, 1);
         chk("t4_stall_id", res_id, 0);
         chk("t4_stall_data", res_data, 32'd63);
         chk("t4_stall_ready", req_ready, 0);
         chk("t4_stall_busy", busy, 1);
         cyc();
      end
      res_ready = 1'b1;
      #1;
      chk("t4_rel_valid", res_valid, 1);
      chk("t4_rel_id", res_id, 0);
      chk("t4_rel_data", res_data, 32'd63);
      chk("t4_rel_grant3", req_ready, 4'b1000);
      cyc();
      req_valid = '0;
      #1;
      chk("t4_r1_id", res_id, 1);
      chk("t4_r1_data", res_data, 32'd143);
      cyc();
      #1;
      chk("t4_r2_id", res_id, 2);
      chk("t4_r2_data", res_data, 32'd100000);
      cyc();
      #1;
      chk("t4_r3_valid", res_valid, 1);
      chk("t4_r3_id", res_id, 3);
      chk("t4_r3_data", res_data, 32'd6);
      cyc();
      #1;
      chk("t4_done_valid", res_valid, 0);
      chk("t4_done_busy", busy, 0);

      // Reset mid-flight discards two issued ops
      set_op(0, 16'd5, 16'd5);
      set_op(1, 16'd6, 16'd6);
      req_valid = 4'b0011;
      #1;
      chk("t5_grant0", req_ready, 4'b0001);
      cyc();
      req_valid = 4'b0010;
      #1;
      chk("t5_grant1", req_ready, 4'b0010);
      cyc();
      req_valid = '0;
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      for (int s = 0; s < 5; s++) begin
         #1;
         chk("t5_no_result", res_valid, 0);
         chk("t5_no_busy", busy, 0);
         cyc();
      end
      req_valid = 4'b1111;
      #1;
      chk("t5_grant_after_rst", req_ready, 4'b0001);
      cyc();
      req_valid = '0;
      cyc();
      cyc();
      #1;
      chk("t5_res_valid", res_valid, 1);
      chk("t5_res_id", res_id, 0);
      chk("t5_res_data", res_data, 32'd25);
      cyc();
      #1;
      chk("t5_done_valid", res_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
